// File: rtl/sem_bit_deserializer.sv
// ---------------------------------------------------------------------------
// sem_bit_deserializer
//
// Receive-side endpoint of the single-bit semaphore link. Bits arriving on the
// B side of the semaphore connector are accepted through a valid/ready
// handshake. They are assembled LSB-first into WIDTH-bit words. Each completed
// word goes into a DEPTH-entry circular FIFO, which a byte-level consumer
// drains through a second valid/ready handshake.
//
// A full FIFO withdraws bit-side ready, so backpressure reaches the bit link
// and no bit is ever dropped.
//
// Ports:
//   clk_s             in   1               single clock, rising edge
//   rst_s             in   1               synchronous active-high reset
//   sema_valid_i_s_B  in   1               connector holds a bit
//   sema_data_i_s_B   in   1               bit value
//   sema_ready_o_s_B  out  1               bit accepted this cycle when valid
//   flush_i           in   1               discard the partially built word
//   byte_valid_o      out  1               FIFO head word available
//   byte_data_o       out  WIDTH           FIFO head word
//   byte_ready_i      in   1               consumer takes the head word
//   bit_cnt_o         out  $clog2(WIDTH)   bits collected in current word
//   fifo_level_o      out  $clog2(DEPTH)+1 words held in the FIFO
// ---------------------------------------------------------------------------
module sem_bit_deserializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_s,
    input  logic                       rst_s,
    input  logic                       sema_valid_i_s_B,
    input  logic                       sema_data_i_s_B,
    output logic                       sema_ready_o_s_B,
    input  logic                       flush_i,
    output logic                       byte_valid_o,
    output logic [WIDTH-1:0]           byte_data_o,
    input  logic                       byte_ready_i,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt_o,
    output logic [$clog2(DEPTH):0]     fifo_level_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

    // Pointer advance; DEPTH is a power of two, so natural overflow wraps.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_W'(1);
    endfunction

    // The top bit of a word is never stored; it comes straight from the link
    // on the completing accept.
    logic [WIDTH-2:0] shift_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;

    logic             ready_s;
    logic             bit_acc_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] push_word_s;

    // Handshake decode. Ready depends only on reset, flush and registered
    // level, never on sema_valid_i_s_B or byte_ready_i. A word push therefore
    // always finds a free slot.
    always_comb begin
        ready_s     = ~rst_s & ~flush_i & (level_r != LVL_FULL);
        bit_acc_s   = sema_valid_i_s_B & ready_s;
        push_s      = bit_acc_s & (bit_cnt_r == CNT_LAST);
        pop_s       = byte_ready_i & (level_r != LVL_ZERO);
        push_word_s = {sema_data_i_s_B, shift_r};
    end

    // Word assembly: LSB-first shift register and bit counter.
    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            shift_r   <= {(WIDTH-1){1'b0}};
            bit_cnt_r <= CNT_ZERO;
        end else if (flush_i) begin
            shift_r   <= {(WIDTH-1){1'b0}};
            bit_cnt_r <= CNT_ZERO;
        end else if (bit_acc_s) begin
            if (bit_cnt_r == CNT_LAST) begin
                bit_cnt_r <= CNT_ZERO;
            end else begin
                shift_r[bit_cnt_r] <= sema_data_i_s_B;
                bit_cnt_r          <= bit_cnt_r + CNT_ONE;
            end
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Output FIFO: storage, pointers and level counter.
    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WORD_ZERO;
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_word_s;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            // A simultaneous push and pop leaves the level unchanged.
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    assign sema_ready_o_s_B = ready_s;
    assign byte_valid_o     = (level_r != LVL_ZERO);
    assign byte_data_o      = mem_r[rd_ptr_r];
    assign bit_cnt_o        = bit_cnt_r;
    assign fifo_level_o     = level_r;

endmodule
